// File: rtl/fp32_booth4_mul.sv
// fp32_booth4_mul: iterative FP32 multiplier, one radix-4 Booth digit per cycle.
// Fixed 14-cycle latency from the accepting edge to done, round to nearest-even,
// denormal inputs and tiny results flush to zero.
// Optional build macro FP32_MUL_FLAGS_EN adds the 4-bit flags port
// {invalid, overflow, underflow, inexact}.
module fp32_booth4_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
`ifdef FP32_MUL_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [31:0]        a_reg, b_reg;
    logic signed [27:0] acc;
    logic [23:0]        low;
    logic               lost;      // OR of product bits shifted below the low register
    logic [26:0]        mplr;
    logic               accept;

    logic signed [27:0] ma_s, addend, sum;

    logic [45:0]        ph;
    logic               norm, g, r, s;
    logic [23:0]        mant;
    logic [24:0]        rnd;
    logic signed [9:0]  e;
    logic               sgn;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               invalid, is_inf, is_zero, ovf, unf;
    logic [31:0]        result;
`ifdef FP32_MUL_FLAGS_EN
    logic [3:0]         flags_nxt;
`endif

    // Nearest-even increment; bit 24 of the result is the mantissa carry-out
    function automatic logic [24:0] round_rne(input logic [23:0] m, input logic gb,
                                              input logic rb, input logic sb);
        return {1'b0, m} + {24'd0, gb & (rb | sb | m[0])};
    endfunction

    // Pack sign/exponent/fraction, saturating to inf above range and flushing to zero below
    function automatic logic [31:0] pack_sat(input logic sg, input logic signed [9:0] ex,
                                             input logic [22:0] frac);
        logic [31:0] res;
        if (ex >= 10'sd255)
            res = {sg, 8'hFF, 23'd0};
        else if (ex <= 10'sd0)
            res = {sg, 31'd0};
        else
            res = {sg, ex[7:0], frac};
        return res;
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == ITER) || (state == ROUND);
    assign done   = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a start in DONE is treated exactly like a start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (cnt == 4'd12) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = start ? ITER : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth digit recode of the low three multiplier bits and accumulator add
    always_comb begin
        ma_s   = $signed({4'd0, 1'b1, a_reg[22:0]});
        addend = 28'sd0;
        case (mplr[2:0])
            3'b001, 3'b010: addend = ma_s;
            3'b011:         addend = ma_s <<< 1;
            3'b100:         addend = ~(ma_s <<< 1) + 28'sd1;
            3'b101, 3'b110: addend = ~ma_s + 28'sd1;
            default:        addend = 28'sd0;
        endcase
        sum = acc + addend;
    end

    // Normalize, round, exponent and special-case selection for the ROUND edge
    always_comb begin
        ph   = {acc[21:0], low};   // product bits [47:2]
        norm = ph[45];
        if (norm) begin
            mant = ph[45:22];
            g    = ph[21];
            r    = ph[20];
            s    = (|ph[19:0]) | lost;
        end else begin
            mant = ph[44:21];
            g    = ph[20];
            r    = ph[19];
            s    = (|ph[18:0]) | lost;
        end
        rnd = round_rne(mant, g, r, s);
        e   = $signed({2'b00, a_reg[30:23]}) + $signed({2'b00, b_reg[30:23]}) - 10'sd127
              + $signed({9'd0, norm}) + $signed({9'd0, rnd[24]});

        sgn     = a_reg[31] ^ b_reg[31];
        a_zero  = ~|a_reg[30:23];
        b_zero  = ~|b_reg[30:23];
        a_nan   = (&a_reg[30:23]) & (|a_reg[22:0]);
        b_nan   = (&b_reg[30:23]) & (|b_reg[22:0]);
        a_inf   = (&a_reg[30:23]) & ~(|a_reg[22:0]);
        b_inf   = (&b_reg[30:23]) & ~(|b_reg[22:0]);
        invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        is_inf  = ~invalid & (a_inf | b_inf);
        is_zero = ~invalid & ~is_inf & (a_zero | b_zero);
        ovf     = ~invalid & ~is_inf & ~is_zero & (e >= 10'sd255);
        unf     = ~invalid & ~is_inf & ~is_zero & (e <= 10'sd0);

        if (invalid)
            result = 32'h7FC00000;
        else if (is_inf)
            result = {sgn, 8'hFF, 23'd0};
        else if (is_zero)
            result = {sgn, 31'd0};
        else
            result = pack_sat(sgn, e, rnd[22:0]);

`ifdef FP32_MUL_FLAGS_EN
        flags_nxt = {invalid, ovf, unf,
                     ~invalid & ~is_inf & ~is_zero & (g | r | s | ovf | unf)};
`endif
    end

    // Operand capture, Booth iteration and result registration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            low     <= '0;
            lost    <= 1'b0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef FP32_MUL_FLAGS_EN
            flags   <= '0;
`endif
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            low   <= '0;
            lost  <= 1'b0;
            mplr  <= {2'b00, 1'b1, b[22:0], 1'b0};
            cnt   <= '0;
        end else if (state == ITER) begin
            acc  <= sum >>> 2;
            low  <= {sum[1:0], low[23:2]};
            lost <= lost | (|low[1:0]);
            mplr <= mplr >> 2;
            cnt  <= cnt + 4'd1;
        end else if (state == ROUND) begin
            product <= result;
`ifdef FP32_MUL_FLAGS_EN
            flags   <= flags_nxt;
`endif
        end
    end

endmodule
